// File: rtl/alu_iter_exec_if.sv
// alu_iter_exec_if: operand/code request and result/flag response handshakes
// between issue, the iterative ALU and writeback.
interface alu_iter_exec_if #(parameter int DATA_WIDTH = 32);
    logic in_valid, in_ready, out_valid, out_ready, zero, illegal;
    logic [3:0] aluctl;
    logic [DATA_WIDTH-1:0] op_a, op_b, result;
    modport master(
        output in_valid, aluctl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );
    modport slave(
        input  in_valid, aluctl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_iter_exec.sv
// alu_iter_exec: multi-cycle ALU, SLICE_WIDTH bits per cycle LSB first with a
// carry chained between slices; result and flags held until handed off.
module alu_iter_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    alu_iter_exec_if.slave bus
);
    localparam int NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int KW = NSLICE > 1 ? $clog2(NSLICE) : 1;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_XOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, result_q, result_d, fin;
    logic [3:0]              op_q, op_d;
    logic [KW-1:0]           k_q, k_d;
    logic                    carry_q, carry_d, zero_q, zero_d, illegal_q, illegal_d;
    logic [SLICE_WIDTH-1:0]  a_s, b_s, slice_r;
    logic [SLICE_WIDTH:0]    sum;
    logic                    subtract, legal, last, lt;
    int                      sh;

    always_comb begin
        sh       = int'(k_q) * SLICE_WIDTH;
        a_s      = SLICE_WIDTH'(a_q >> sh);
        b_s      = SLICE_WIDTH'(b_q >> sh);
        subtract = op_q == OP_SUB || op_q == OP_SLT;
        legal    = op_q inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_XOR};
        sum      = {1'b0, a_s} + {1'b0, subtract ? ~b_s : b_s} + {{SLICE_WIDTH{1'b0}}, carry_q};
        slice_r  = op_q == OP_AND ? a_s & b_s :
                   op_q == OP_OR  ? a_s | b_s :
                   op_q == OP_XOR ? a_s ^ b_s :
                   (op_q == OP_ADD || subtract) ? sum[SLICE_WIDTH-1:0] : '0;
        fin      = result_q | (DATA_WIDTH'(slice_r) << sh);
        last     = k_q == KW'(NSLICE - 1);
        // Signs differ: A<B exactly when A is negative; otherwise the difference sign decides.
        lt       = a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1] ? a_q[DATA_WIDTH-1] : slice_r[SLICE_WIDTH-1];
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        k_d       = k_q;
        carry_d   = carry_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d   = BUSY;
                a_d       = bus.op_a;
                b_d       = bus.op_b;
                op_d      = bus.aluctl;
                k_d       = '0;
                carry_d   = bus.aluctl == OP_SUB || bus.aluctl == OP_SLT;
                result_d  = '0;
                zero_d    = 1'b0;
                illegal_d = 1'b0;
            end
            BUSY: begin
                result_d = last && op_q == OP_SLT ? DATA_WIDTH'(lt) : fin;
                carry_d  = sum[SLICE_WIDTH];
                k_d      = last ? '0 : k_q + 1'b1;
                if (last) begin
                    state_d   = DONE;
                    zero_d    = result_d == '0;
                    illegal_d = !legal;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            k_q       <= '0;
            carry_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            k_q       <= k_d;
            carry_q   <= carry_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_iter_exec.sv
// tb_alu_iter_exec: directed and randomized operations against a plain
// arithmetic reference, including latency, backpressure and async reset.
module tb_alu_iter_exec;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    alu_iter_exec_if #(.DATA_WIDTH(32)) bus();

    alu_iter_exec #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill);
        ill = 1'b0;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: r = a ^ b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
    endfunction

    task automatic start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.aluctl   = op;
        bus.op_a     = a;
        bus.op_b     = b;
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'($urandom);
        bus.aluctl   = 4'($urandom);
        bus.op_a     = $urandom;
        bus.op_b     = $urandom;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    task automatic finish_op(input string tag, input logic [31:0] r, input logic ill);
        chk({tag, "_result"}, bus.result, r);
        chk({tag, "_zero"}, 32'(bus.zero), 32'(r == 32'd0));
        chk({tag, "_illegal"}, 32'(bus.illegal), 32'(ill));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic ill);
        start(op, a, b);
        wait_done(tag);
        finish_op(tag, r, ill);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, a, b;
        logic        ill;
        logic [3:0]  op;
        logic [3:0]  codes [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
        bus.in_valid = 1'b0; bus.aluctl = '0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_carry", 4'b0010, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0);
        run_op("sub_eq",    4'b0110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op("sub_wrap",  4'b0110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        run_op("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1'b0);
        run_op("slt_pos",   4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("slt_eq",    4'b0111, 32'd5, 32'd5, 32'd0, 1'b0);
        run_op("and",       4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        run_op("or",        4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        run_op("xor",       4'b1100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        run_op("illegal",   4'b1010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b1);

        // Backpressure: hold DONE while a second request waits.
        start(4'b0010, 32'h1111_1111, 32'h2222_2222);
        wait_done("bp_first");
        bus.in_valid = 1'b1; bus.aluctl = 4'b0010; bus.op_a = 32'd10; bus.op_b = 32'd20;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_result", bus.result, 32'h3333_3333);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        wait_done("bp_second");
        finish_op("bp_second", 32'd30, 1'b0);

        // Asynchronous reset two slices into an operation.
        start(4'b0010, 32'h1111_1111, 32'h2222_2222);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_result", bus.result, 32'd0);
        chk("arst_zero", 32'(bus.zero), 32'd0);
        chk("arst_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst_add", 4'b0010, 32'd3, 32'd4, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = (i % 7 == 6) ? 4'($urandom) : codes[$urandom_range(0, 5)];
            a  = $urandom;
            b  = (i % 5 == 0) ? a : (i % 5 == 1) ? 32'($urandom_range(0, 255)) : $urandom;
            model(op, a, b, r, ill);
            run_op("rand", op, a, b, r, ill);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
